// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store memory arbiter: station indices,
// result tags and the grant-type encoding.
package lsq_pkg;

    localparam int N_STN = 4;

    localparam logic [1:0] IDX_F0 = 2'd0;
    localparam logic [1:0] IDX_F1 = 2'd1;
    localparam logic [1:0] IDX_S0 = 2'd2;
    localparam logic [1:0] IDX_S1 = 2'd3;

    localparam logic [3:0] TAG_F0 = 4'b0100;
    localparam logic [3:0] TAG_F1 = 4'b0101;
    localparam logic [3:0] TAG_S0 = 4'b0110;
    localparam logic [3:0] TAG_S1 = 4'b0111;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FWD  = 2'd3
    } gnt_e;

    function automatic logic [3:0] stn_tag(input logic [1:0] idx);
        logic [3:0] tag;
        case (idx)
            IDX_F0:  tag = TAG_F0;
            IDX_F1:  tag = TAG_F1;
            IDX_S0:  tag = TAG_S0;
            default: tag = TAG_S1;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/lsq_age_matrix.sv
// Age matrix over the four stations with oldest-requester select.
// older[i][j] = 1 means station i was allocated before station j.
import lsq_pkg::*;

module lsq_age_matrix #(
    parameter int N = N_STN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        alloc,
    input  logic [N-1:0]        slot,
    input  logic [N-1:0]        req,
    output logic [N-1:0][N-1:0] older,
    output logic [N-1:0]        gnt
);

    // A new entry is younger than everything already present; same-cycle
    // entries are ordered by slot, then by fixed station index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i != j) begin
                        if (alloc[i] && alloc[j])
                            older[i][j] <= (slot[i] < slot[j]) ||
                                           ((slot[i] == slot[j]) && (i < j));
                        else if (alloc[i])
                            older[i][j] <= 1'b0;
                        else if (alloc[j])
                            older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = req[i];
            for (int j = 0; j < N; j++) begin
                if ((j != i) && req[j] && older[j][i])
                    gnt[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Two-load / two-store queue arbitrating one single-port memory, oldest first,
// with WAR/WAW/RAW ordering. Define LSQ_FWD_EN for store-to-load forwarding.
import lsq_pkg::*;

module lsq_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int TW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ld_alloc,
    input  logic [2*AW-1:0] ld_addr,
    input  logic [1:0]      ld_slot,
    input  logic [1:0]      st_alloc,
    input  logic [1:0]      st_slot,
    input  logic [2*AW-1:0] st_addr,
    input  logic [2*DW-1:0] st_data,
    input  logic [1:0]      st_dvld,
    output logic [1:0]      ld_busy,
    output logic [1:0]      st_busy,
    output logic [1:0]      st_done,
    output logic            res_vld,
    output logic [TW+DW-1:0] res_bus,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

`ifdef LSQ_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [N_STN-1:0] STORE_MASK = 4'b1100;

    logic [N_STN-1:0]             busy, alloc_req, alloc_acc, slot, free, elig, gnt;
    logic [N_STN-1:0][N_STN-1:0]  older, match;
    logic [AW-1:0]                addr_q [N_STN];
    logic [DW-1:0]                sdata_q [2];
    logic [1:0]                   sdvld_q;
    logic [1:0]                   ld_fwd_need;
    logic [DW-1:0]                ld_fwd_src [2];
    gnt_e                         gnt_type;
    logic [1:0]                   gnt_idx;
    logic [DW-1:0]                fwd_data;

    logic                         pend_vld_p1;
    gnt_e                         pend_type_p1;
    logic [1:0]                   pend_idx_p1;
    logic [DW-1:0]                fwd_data_p1;

    assign alloc_req = {st_alloc, ld_alloc};
    assign slot      = {st_slot, ld_slot};

    // A station with a granted operation stays busy one more cycle and is released here.
    always_comb begin
        free = '0;
        for (int i = 0; i < N_STN; i++)
            free[i] = pend_vld_p1 && (pend_idx_p1 == 2'(i));
    end

    assign alloc_acc = alloc_req & (~busy | free);

    lsq_age_matrix #(.N(N_STN)) u_age (
        .clk   (clk),
        .rst_n (rst_n),
        .alloc (alloc_acc),
        .slot  (slot),
        .req   (elig),
        .older (older),
        .gnt   (gnt)
    );

    // match[i][j]: station j is busy, older than i and targets the same address.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_STN; i++)
            for (int j = 0; j < N_STN; j++)
                match[i][j] = busy[j] && older[j][i] && (addr_q[j] == addr_q[i]);
    end

    always_comb begin
        elig        = '0;
        ld_fwd_need = '0;
        ld_fwd_src  = '{default: '0};
        for (int l = 0; l < 2; l++) begin
            logic blk, blk_nodata;
            blk        = |(match[l] & STORE_MASK);
            blk_nodata = (match[l][IDX_S0] && !sdvld_q[0]) ||
                         (match[l][IDX_S1] && !sdvld_q[1]);
            ld_fwd_need[l] = blk;
            // Youngest matching older store supplies forwarded data.
            if (match[l][IDX_S0] && match[l][IDX_S1])
                ld_fwd_src[l] = older[IDX_S0][IDX_S1] ? sdata_q[1] : sdata_q[0];
            else if (match[l][IDX_S1])
                ld_fwd_src[l] = sdata_q[1];
            else
                ld_fwd_src[l] = sdata_q[0];
            elig[l] = busy[l] && !free[l] && (!blk || (FWD_EN && !blk_nodata));
        end
        for (int s = 0; s < 2; s++)
            elig[s+2] = busy[s+2] && !free[s+2] && sdvld_q[s] && !(|match[s+2]);
    end

    always_comb begin
        gnt_type = NONE;
        gnt_idx  = '0;
        fwd_data = '0;
        for (int l = 0; l < 2; l++) begin
            if (gnt[l]) begin
                gnt_idx = 2'(l);
                if (ld_fwd_need[l]) begin
                    gnt_type = FWD;
                    fwd_data = ld_fwd_src[l];
                end else begin
                    gnt_type = RD;
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (gnt[s+2]) begin
                gnt_idx  = 2'(s + 2);
                gnt_type = WR;
            end
        end
    end

    assign mem_en    = (gnt_type == RD) || (gnt_type == WR);
    assign mem_we    = (gnt_type == WR);
    assign mem_addr  = mem_en ? addr_q[gnt_idx] : '0;
    assign mem_wdata = mem_we ? sdata_q[gnt_idx[0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            sdvld_q <= '0;
            for (int i = 0; i < N_STN; i++) addr_q[i] <= '0;
            for (int s = 0; s < 2; s++) sdata_q[s] <= '0;
        end else begin
            busy <= (busy & ~free) | alloc_acc;
            for (int l = 0; l < 2; l++)
                if (alloc_acc[l]) addr_q[l] <= ld_addr[l*AW +: AW];
            for (int s = 0; s < 2; s++) begin
                if (alloc_acc[s+2]) begin
                    addr_q[s+2] <= st_addr[s*AW +: AW];
                    sdata_q[s]  <= st_data[s*DW +: DW];
                    sdvld_q[s]  <= st_dvld[s];
                end else if (busy[s+2] && !sdvld_q[s]) begin
                    sdata_q[s]  <= st_data[s*DW +: DW];
                    sdvld_q[s]  <= st_dvld[s];
                end
            end
        end
    end

    // ---- grant -> completion stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_p1  <= 1'b0;
            pend_type_p1 <= NONE;
            pend_idx_p1  <= '0;
            fwd_data_p1  <= '0;
        end else begin
            pend_vld_p1  <= (gnt_type != NONE);
            pend_type_p1 <= gnt_type;
            pend_idx_p1  <= gnt_idx;
            fwd_data_p1  <= fwd_data;
        end
    end

    assign res_vld = pend_vld_p1 && ((pend_type_p1 == RD) || (pend_type_p1 == FWD));
    assign res_bus = res_vld ? {TW'(stn_tag(pend_idx_p1)),
                                (pend_type_p1 == FWD) ? fwd_data_p1 : mem_rdata}
                             : '0;

    always_comb begin
        st_done = '0;
        for (int s = 0; s < 2; s++)
            st_done[s] = pend_vld_p1 && (pend_type_p1 == WR) && (pend_idx_p1 == 2'(s + 2));
    end

    assign ld_busy = busy[1:0];
    assign st_busy = busy[3:2];

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed testbench for lsq_mem_arbiter with a registered single-port memory
// model; expectations follow the LSQ_FWD_EN setting of the build.
module tb_lsq_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      ld_alloc, ld_slot, st_alloc, st_slot, st_dvld;
    logic [2*AW-1:0] ld_addr, st_addr;
    logic [2*DW-1:0] st_data;
    logic [1:0]      ld_busy, st_busy, st_done;
    logic            res_vld, mem_en, mem_we;
    logic [TW+DW-1:0] res_bus;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsq_mem_arbiter #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_alloc  (ld_alloc),
        .ld_addr   (ld_addr),
        .ld_slot   (ld_slot),
        .st_alloc  (st_alloc),
        .st_slot   (st_slot),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_dvld   (st_dvld),
        .ld_busy   (ld_busy),
        .st_busy   (st_busy),
        .st_done   (st_done),
        .res_vld   (res_vld),
        .res_bus   (res_bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory: fixed background contents overlaid by anything written.
    logic [255:0] wr_valid = '0;
    logic [7:0]   wr_mem [256];

    function automatic logic [7:0] bg(input logic [7:0] a);
        case (a)
            8'h10:   return 8'h5A;
            8'h40:   return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        return wr_valid[a] ? wr_mem[a] : bg(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_mem[mem_addr]   <= mem_wdata;
            wr_valid[mem_addr] <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= mem_rd(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_alloc = '0; ld_slot = '0; ld_addr = '0;
        st_alloc = '0; st_slot = '0; st_addr = '0;
        st_data  = '0; st_dvld = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ld_busy", 32'(ld_busy), 32'h0);
        chk("rst_st_busy", 32'(st_busy), 32'h0);
        chk("rst_mem_en",  32'(mem_en),  32'h0);
        chk("rst_res_vld", 32'(res_vld), 32'h0);
        chk("rst_st_done", 32'(st_done), 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Load only
        ld_alloc = 2'b01; ld_addr = 16'h0010;
        tick(); idle();
        chk("ld_busy",    32'(ld_busy),  32'h1);
        chk("ld_mem_en",  32'(mem_en),   32'h1);
        chk("ld_mem_we",  32'(mem_we),   32'h0);
        chk("ld_addr",    32'(mem_addr), 32'h10);
        tick();
        chk("ld_res_vld", 32'(res_vld),  32'h1);
        chk("ld_res_bus", 32'(res_bus),  32'h45A);
        chk("ld_no_req",  32'(mem_en),   32'h0);
        tick();
        chk("ld_freed",   32'(ld_busy),  32'h0);
        chk("ld_res_off", 32'(res_vld),  32'h0);

        // RAW: S0 slot0 store and F1 slot1 load to 0x20
        st_alloc = 2'b01; st_slot = 2'b00; st_addr = 16'h0020; st_data = 16'h0033; st_dvld = 2'b01;
        ld_alloc = 2'b10; ld_slot = 2'b10; ld_addr = 16'h2000;
        tick(); idle();
        chk("raw_wr_en",   32'(mem_en),    32'h1);
        chk("raw_wr_we",   32'(mem_we),    32'h1);
        chk("raw_wr_addr", 32'(mem_addr),  32'h20);
        chk("raw_wr_data", 32'(mem_wdata), 32'h33);
        tick();
        chk("raw_st_done", 32'(st_done),   32'h1);
        chk("raw_hold",    32'(mem_en),    32'h0);
        chk("raw_no_res",  32'(res_vld),   32'h0);
        tick();
`ifdef LSQ_FWD_EN
        chk("raw_fwd_vld", 32'(res_vld),   32'h1);
        chk("raw_fwd_bus", 32'(res_bus),   32'h533);
        chk("raw_fwd_nrd", 32'(mem_en),    32'h0);
        tick();
        chk("raw_fwd_free", 32'(ld_busy),  32'h0);
`else
        chk("raw_st_free", 32'(st_busy),   32'h0);
        chk("raw_rd_en",   32'(mem_en),    32'h1);
        chk("raw_rd_we",   32'(mem_we),    32'h0);
        chk("raw_rd_addr", 32'(mem_addr),  32'h20);
        tick();
        chk("raw_rd_vld",  32'(res_vld),   32'h1);
        chk("raw_rd_bus",  32'(res_bus),   32'h533);
`endif
        tick();

        // WAW: S1 (slot0, 0x11) older than S0 (slot1, 0x22), both 0x30
        st_alloc = 2'b11; st_slot = 2'b01; st_addr = 16'h3030; st_data = 16'h1122; st_dvld = 2'b11;
        tick(); idle();
        chk("waw_first_we",   32'(mem_we),    32'h1);
        chk("waw_first_data", 32'(mem_wdata), 32'h11);
        tick();
        chk("waw_s1_done",    32'(st_done),   32'h2);
        chk("waw_hold",       32'(mem_en),    32'h0);
        tick();
        chk("waw_second_we",  32'(mem_we),    32'h1);
        chk("waw_second_adr", 32'(mem_addr),  32'h30);
        chk("waw_second_dat", 32'(mem_wdata), 32'h22);
        tick();
        chk("waw_s0_done",    32'(st_done),   32'h1);
        chk("waw_mem30",      32'(mem_rd(8'h30)), 32'h22);

        // WAR: F0 (slot0) older than S1 (slot1), both 0x40
        ld_alloc = 2'b01; ld_slot = 2'b00; ld_addr = 16'h0040;
        st_alloc = 2'b10; st_slot = 2'b10; st_addr = 16'h4000; st_data = 16'h7700; st_dvld = 2'b10;
        tick(); idle();
        chk("war_rd_en",   32'(mem_en),   32'h1);
        chk("war_rd_we",   32'(mem_we),   32'h0);
        chk("war_rd_addr", 32'(mem_addr), 32'h40);
        tick();
        chk("war_res_bus", 32'(res_bus),  32'h401);
        chk("war_hold",    32'(mem_en),   32'h0);
        tick();
        chk("war_wr_we",   32'(mem_we),   32'h1);
        chk("war_wr_data", 32'(mem_wdata), 32'h77);
        tick();
        chk("war_done",    32'(st_done),  32'h2);
        chk("war_mem40",   32'(mem_rd(8'h40)), 32'h77);
        tick();

        // Reset while a load read is in flight
        ld_alloc = 2'b01; ld_addr = 16'h0010;
        tick(); idle();
        chk("rmr_grant", 32'(mem_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmr_res_vld", 32'(res_vld), 32'h0);
        chk("rmr_busy",    32'(ld_busy), 32'h0);
        chk("rmr_mem_en",  32'(mem_en),  32'h0);
        tick();
        chk("rmr_res_hold", 32'(res_vld), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rmr_idle_res", 32'(res_vld), 32'h0);
        ld_alloc = 2'b10; ld_slot = 2'b00; ld_addr = 16'h4000;
        tick(); idle();
        chk("rmr_new_addr", 32'(mem_addr), 32'h40);
        tick();
        chk("rmr_new_res",  32'(res_bus),  32'h577);
        tick();

        // Allocation to a busy station is ignored
        ld_alloc = 2'b01; ld_addr = 16'h0010;
        tick();
        ld_alloc = 2'b01; ld_addr = 16'h0030;
        chk("busy_addr", 32'(mem_addr), 32'h10);
        tick(); idle();
        chk("busy_res",  32'(res_bus),  32'h45A);
        tick();
        chk("busy_free", 32'(ld_busy),  32'h0);
        chk("busy_nreq", 32'(mem_en),   32'h0);

        // Allocation to a station being freed is accepted
        ld_alloc = 2'b01; ld_addr = 16'h0010;
        tick(); idle();
        tick();
        ld_alloc = 2'b01; ld_addr = 16'h0030;
        chk("refill_res1", 32'(res_bus), 32'h45A);
        tick(); idle();
        chk("refill_busy", 32'(ld_busy),  32'h1);
        chk("refill_addr", 32'(mem_addr), 32'h30);
        tick();
        chk("refill_res2", 32'(res_bus),  32'h422);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsq_mem_arbiter.md
LSQ_MEM_ARBITER -- requirements
Module: lsq_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 8, memory address width; DW, 8, data width; TW, 4, tag width (res_bus width = TW+DW).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ld_alloc  input  2  one-cycle pulse per load station F0/F1: capture ld_addr and ld_slot.
REQ-005 ld_addr  input  2*AW  load addresses, F0 in [AW-1:0].
REQ-006 ld_slot  input  2  0 = instruction1 (older), 1 = instruction2 (younger), for same-cycle ordering.
REQ-007 st_alloc / st_slot  input  2 / 2  store stations S0/S1; same meaning as ld_alloc / ld_slot.
REQ-008 st_addr / st_data  input  2*AW / 2*DW  store address and data; data is sampled every cycle until st_dvld is seen.
REQ-009 st_dvld  input  2  store data valid; latched once per allocation.
REQ-010 ld_busy / st_busy  output  2 / 2  station occupied.
REQ-011 st_done  output  2  one-cycle pulse when the store is written.
REQ-012 res_vld / res_bus  output  1 / TW+DW  load result {tag, data}; tag F0 = 4'b0100, F1 = 4'b0101.
REQ-013 mem_en, mem_we, mem_addr, mem_wdata  output  1, 1, AW, DW  single-port memory request.
REQ-014 mem_rdata  input  DW  read data, valid the cycle after a read request.

Function
REQ-015 At most one memory request (or one forward) SHALL be granted per cycle; the winner is the oldest eligible station.
REQ-016 A 4x4 age matrix SHALL track order. Stations allocated in earlier cycles are older. Within one cycle, slot 0 is older than slot 1. For equal slots the fixed order F0, F1, S0, S1 applies.
REQ-017 A store SHALL be eligible when all of the following hold:
- busy, and data latched;
- no older busy load to the same address (WAR);
- no older busy store to the same address (WAW).
REQ-018 A load SHALL be eligible for a memory read when no older busy store matches its address.
REQ-019 Store grant: mem_en=1, mem_we=1 in the grant cycle. The station is freed and st_done pulses on the following cycle.
REQ-020 Load grant: mem_en=1, mem_we=0. The next cycle drives res_vld=1, res_bus={tag, mem_rdata}, and frees the station.
REQ-021 An allocation to a busy station SHALL be ignored; state is unchanged.
REQ-022 An allocation to a station being freed in the same cycle SHALL be accepted; the new entry is youngest.
REQ-023 With nothing eligible, mem_en=0 and res_vld=0.

Reset
REQ-024 On rst_n low, all outputs SHALL go to 0 immediately and all stations, latched data and age bits SHALL clear; any in-flight read result is discarded.
REQ-025 The first grant SHALL occur no earlier than the second rising edge after rst_n deasserts.

Configuration
REQ-026 With LSQ_FWD_EN defined, a load blocked only by older matching stores whose data is latched SHALL be eligible for forwarding. Forwarding takes data from the youngest such store, issues no memory request, and returns res_vld one cycle after the grant.
REQ-027 Without LSQ_FWD_EN, a blocked load SHALL wait until every older matching store is done.

Structure
REQ-028 A shared package (lsq_pkg) SHALL hold the station index constants, the tag codes (F0 4'b0100, F1 4'b0101, S0 4'b0110, S1 4'b0111) and the grant-type enum (NONE, RD, WR, FWD).
REQ-029 The age matrix with oldest-select SHALL be one sub-module, lsq_age_matrix. Hazard checks, grant and result registers SHALL stay in the top.

Verification
REQ-030 Load-only: alloc F0 addr 0x10 (mem[0x10]=0x5A) -> mem_en/!we addr 0x10 next cycle; following cycle res_bus=0x45A, res_vld=1.
REQ-031 RAW: same cycle S0 slot0 addr 0x20 data 0x33 dvld, F1 slot1 addr 0x20 -> store writes first.
- Without LSQ_FWD_EN: F1 returns 0x533 after st_done.
- With LSQ_FWD_EN: F1 returns 0x533 with no read, one cycle after its grant.
REQ-032 WAW: S1 (older, 0x11) and S0 (younger, 0x22) both to addr 0x30 -> S1 write precedes S0; final mem[0x30]=0x22.
REQ-033 WAR: F0 addr 0x40 older than S1 addr 0x40 data 0x77 (mem[0x40]=0x01) -> F0 returns 0x401; S1 writes only after F0 is freed.
REQ-034 Reset mid-read: rst_n low in the cycle after a load grant -> res_vld stays 0, busy=0; a load allocated after reset completes normally.
REQ-035 Busy re-alloc: second ld_alloc[0] while F0 is busy with a different address -> ignored; F0 returns data for the original address only.
